// File: rtl/pc_fetch_unit_pkg.sv
// Shared core definitions for the multi-cycle RISC-V fetch stage:
// opcode and branch funct3 constants, reset defaults and the fetch state type.
package pc_fetch_unit_pkg;

  // Base RV32I major opcodes seen by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Branch funct3 encodings the decoder turns into beq/bne/blt/bge strobes
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Reset PC and the instruction register's power-on content (addi x0,x0,0)
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // RUN: normal fetch/execute; HALT: sticky trap after a misaligned PC target
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_branch_resolve.sv
// Branch resolution: turns the one-hot branch strobes and the flags of the
// ALU subtract into a single taken decision. Shared with the pipelined core.
module branch_resolve (
  input  logic beq,
  input  logic bne,
  input  logic blt,
  input  logic bge,
  input  logic Zero,
  input  logic Negative,
  input  logic Overflow,
  output logic taken
);

  logic w_lt;

  // Signed less-than from the subtract: sign corrected by overflow
  assign w_lt = Negative ^ Overflow;

  // OR of all strobe/condition pairs; several strobes at once still yields a defined result
  always_comb begin
    taken = (beq & Zero) | (bne & ~Zero) | (blt & w_lt) | (bge & ~w_lt);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC / instruction-register stage of the multi-cycle core. Holds PC, OldPC
// and Instr, resolves branches, traps misaligned PC targets into a sticky
// HALT state and keeps free-running cycle and retired-instruction counters.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCUpdate,
  input  logic             IRWrite,
  input  logic             beq,
  input  logic             bne,
  input  logic             blt,
  input  logic             bge,
  input  logic             Zero,
  input  logic             Negative,
  input  logic             Overflow,
  input  logic [XLEN-1:0]  Result,
  input  logic [XLEN-1:0]  ReadData,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  OldPC,
  output logic [XLEN-1:0]  Instr,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic             PCWrite,
  output logic             halted,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  fetch_state_e     r_state;
  fetch_state_e     w_next_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_old_pc;
  logic [XLEN-1:0]  r_instr;
  logic [XLEN-1:0]  r_trap_pc;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  logic w_taken;
  logic w_wr_req;
  logic w_misalign;
  logic w_pc_write;
  logic w_ir_en;
  logic w_trap_en;
  logic w_cycle_en;

  branch_resolve u_branch_resolve (
    .beq      (beq),
    .bne      (bne),
    .blt      (blt),
    .bge      (bge),
    .Zero     (Zero),
    .Negative (Negative),
    .Overflow (Overflow),
    .taken    (w_taken)
  );

  // A PC write is requested either unconditionally or by a taken branch;
  // any such request to a non-word-aligned target is a trap
  always_comb begin
    w_wr_req   = PCUpdate | w_taken;
    w_misalign = w_wr_req & (Result[1:0] != 2'b00);
  end

  // State register; only reset leaves HALT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  // Next state and per-cycle enables; HALT suppresses every update
  always_comb begin
    w_next_state = r_state;
    w_pc_write   = 1'b0;
    w_ir_en      = 1'b0;
    w_trap_en    = 1'b0;
    w_cycle_en   = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        w_pc_write = w_wr_req & ~w_misalign;
        w_ir_en    = IRWrite;
        w_cycle_en = 1'b1;
        if (w_misalign) begin
          w_trap_en    = 1'b1;
          w_next_state = ST_HALT;
        end
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // PC, OldPC, Instr and trap address; OldPC samples PC before this edge's write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_old_pc  <= RESET_PC;
      r_instr   <= XLEN'(NOP_INSTR);
      r_trap_pc <= '0;
    end else begin
      if (w_pc_write) r_pc <= Result;
      if (w_ir_en) begin
        r_instr  <= ReadData;
        r_old_pc <= r_pc;
      end
      if (w_trap_en) r_trap_pc <= Result;
    end
  end

  // Free-running counters, wrapping naturally; both freeze in HALT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (w_cycle_en) r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
      if (w_ir_en)    r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  // Outputs; PCWrite is forced low while reset is held so nothing downstream sees a write
  always_comb begin
    PC          = r_pc;
    OldPC       = r_old_pc;
    Instr       = r_instr;
    opcode      = r_instr[6:0];
    funct3      = r_instr[14:12];
    PCWrite     = w_pc_write & reset;
    halted      = (r_state == ST_HALT);
    trap_pc     = r_trap_pc;
    cycle_cnt   = r_cycle_cnt;
    instret_cnt = r_instret_cnt;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table for the branch/fetch
// behaviour plus hand-written sequences for trap, async reset and counter wrap.
module tb_pc_fetch_unit;

  typedef struct {
    logic        pcu, irw, beq, bne, blt, bge, z, n, v;
    logic [31:0] result, rdata;
    logic        expPcw;
    logic [31:0] expPc, expOldPc, expInstr, expInstret;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        PCUpdate, IRWrite, beq, bne, blt, bge, Zero, Negative, Overflow;
  logic [31:0] Result, ReadData;

  logic [31:0] PC, OldPC, Instr, trap_pc, cycle_cnt, instret_cnt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        PCWrite, halted;

  logic [31:0] PC4, OldPC4, Instr4, trap_pc4;
  logic [6:0]  opcode4;
  logic [2:0]  funct34;
  logic        PCWrite4, halted4;
  logic [3:0]  cycle_cnt4, instret_cnt4;

  int compared;
  int mismatched;
  int expCycle;

  vec_t vecs[16];

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .PCUpdate(PCUpdate), .IRWrite(IRWrite),
    .beq(beq), .bne(bne), .blt(blt), .bge(bge),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
    .Result(Result), .ReadData(ReadData),
    .PC(PC), .OldPC(OldPC), .Instr(Instr), .opcode(opcode), .funct3(funct3),
    .PCWrite(PCWrite), .halted(halted), .trap_pc(trap_pc),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // Narrow-counter copy so the wrap boundary is reachable in a few cycles
  pc_fetch_unit #(.CNT_W(4)) dutNarrow (
    .clk(clk), .reset(reset), .PCUpdate(PCUpdate), .IRWrite(IRWrite),
    .beq(beq), .bne(bne), .blt(blt), .bge(bge),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
    .Result(Result), .ReadData(ReadData),
    .PC(PC4), .OldPC(OldPC4), .Instr(Instr4), .opcode(opcode4), .funct3(funct34),
    .PCWrite(PCWrite4), .halted(halted4), .trap_pc(trap_pc4),
    .cycle_cnt(cycle_cnt4), .instret_cnt(instret_cnt4)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    PCUpdate = v.pcu; IRWrite = v.irw;
    beq = v.beq; bne = v.bne; blt = v.blt; bge = v.bge;
    Zero = v.z; Negative = v.n; Overflow = v.v;
    Result = v.result; ReadData = v.rdata;
  endtask

  task automatic clearInputs();
    PCUpdate = 0; IRWrite = 0; beq = 0; bne = 0; blt = 0; bge = 0;
    Zero = 0; Negative = 0; Overflow = 0; Result = '0; ReadData = '0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".PC"},      PC, 32'h0);
    checkOutput({tag, ".OldPC"},   OldPC, 32'h0);
    checkOutput({tag, ".Instr"},   Instr, 32'h0000_0013);
    checkOutput({tag, ".trap_pc"}, trap_pc, 32'h0);
    checkOutput({tag, ".halted"},  halted, 1'b0);
    checkOutput({tag, ".cycle"},   cycle_cnt, 32'h0);
    checkOutput({tag, ".instret"}, instret_cnt, 32'h0);
    checkOutput({tag, ".PCWrite"}, PCWrite, 1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    //            pcu irw beq bne blt bge z n v  result        rdata          pcw  pc     oldpc  instr          instret
    vecs[0]  = '{1,  1,  0,  0,  0,  0,  0,0,0, 32'h4,        32'h00500093,  1,   32'h4,  32'h0,  32'h00500093, 32'd1};
    vecs[1]  = '{0,  0,  1,  0,  0,  0,  1,0,0, 32'h40,       32'h0,         1,   32'h40, 32'h0,  32'h00500093, 32'd1};
    vecs[2]  = '{0,  0,  1,  0,  0,  0,  0,0,0, 32'h80,       32'h0,         0,   32'h40, 32'h0,  32'h00500093, 32'd1};
    vecs[3]  = '{0,  0,  0,  1,  0,  0,  0,0,0, 32'h44,       32'h0,         1,   32'h44, 32'h0,  32'h00500093, 32'd1};
    vecs[4]  = '{0,  0,  0,  1,  0,  0,  1,0,0, 32'h48,       32'h0,         0,   32'h44, 32'h0,  32'h00500093, 32'd1};
    vecs[5]  = '{0,  0,  0,  0,  1,  0,  0,1,1, 32'h50,       32'h0,         0,   32'h44, 32'h0,  32'h00500093, 32'd1};
    vecs[6]  = '{0,  0,  0,  0,  1,  0,  0,1,0, 32'h50,       32'h0,         1,   32'h50, 32'h0,  32'h00500093, 32'd1};
    vecs[7]  = '{0,  0,  0,  0,  1,  0,  0,0,0, 32'h60,       32'h0,         0,   32'h50, 32'h0,  32'h00500093, 32'd1};
    vecs[8]  = '{0,  0,  0,  0,  1,  0,  0,0,1, 32'h60,       32'h0,         1,   32'h60, 32'h0,  32'h00500093, 32'd1};
    vecs[9]  = '{0,  0,  0,  0,  0,  1,  0,0,0, 32'h64,       32'h0,         1,   32'h64, 32'h0,  32'h00500093, 32'd1};
    vecs[10] = '{0,  0,  0,  0,  0,  1,  0,0,1, 32'h68,       32'h0,         0,   32'h64, 32'h0,  32'h00500093, 32'd1};
    vecs[11] = '{0,  0,  0,  0,  0,  1,  0,1,0, 32'h68,       32'h0,         0,   32'h64, 32'h0,  32'h00500093, 32'd1};
    vecs[12] = '{0,  0,  0,  0,  0,  1,  0,1,1, 32'h68,       32'h0,         1,   32'h68, 32'h0,  32'h00500093, 32'd1};
    vecs[13] = '{0,  1,  0,  0,  0,  0,  0,0,0, 32'hFF,       32'h00008067,  0,   32'h68, 32'h68, 32'h00008067, 32'd2};
    vecs[14] = '{1,  1,  0,  0,  0,  0,  0,0,0, 32'h6C,       32'h00B51463,  1,   32'h6C, 32'h68, 32'h00B51463, 32'd3};
    vecs[15] = '{0,  0,  0,  0,  0,  0,  0,0,0, 32'h3,        32'h0,         0,   32'h6C, 32'h68, 32'h00B51463, 32'd3};

    // Hold reset with a write request present: PCWrite must stay low
    reset = 1'b0;
    clearInputs();
    PCUpdate = 1'b1;
    Result   = 32'h4;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    checkOutput("reset.opcode", opcode, 7'h13);

    // Release on a falling edge, then run the vector table
    @(negedge clk);
    reset    = 1'b1;
    expCycle = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.PCWrite", i), PCWrite, vecs[i].expPcw);
      @(posedge clk);
      #1;
      expCycle++;
      checkOutput($sformatf("v%0d.PC", i),      PC, vecs[i].expPc);
      checkOutput($sformatf("v%0d.OldPC", i),   OldPC, vecs[i].expOldPc);
      checkOutput($sformatf("v%0d.Instr", i),   Instr, vecs[i].expInstr);
      checkOutput($sformatf("v%0d.instret", i), instret_cnt, vecs[i].expInstret);
      checkOutput($sformatf("v%0d.cycle", i),   cycle_cnt, expCycle);
      checkOutput($sformatf("v%0d.halted", i),  halted, 1'b0);
      if (i == 0) checkOutput("v0.opcode", opcode, 7'h13);
    end
    checkOutput("decode.opcode", opcode, 7'h63);
    checkOutput("decode.funct3", funct3, 3'h1);

    // Misaligned jump with a fetch in the same cycle: IR still latched, PC held
    @(negedge clk);
    clearInputs();
    PCUpdate = 1'b1; IRWrite = 1'b1; Result = 32'h102; ReadData = 32'h12345678;
    #1;
    checkOutput("trap.PCWrite", PCWrite, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("trap.PC",      PC, 32'h6C);
    checkOutput("trap.trap_pc", trap_pc, 32'h102);
    checkOutput("trap.halted",  halted, 1'b1);
    checkOutput("trap.Instr",   Instr, 32'h12345678);
    checkOutput("trap.OldPC",   OldPC, 32'h6C);
    checkOutput("trap.instret", instret_cnt, 32'd4);
    checkOutput("trap.cycle",   cycle_cnt, 32'd17);

    // Everything is frozen in HALT, including a later misaligned target
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      PCUpdate = 1'b1; IRWrite = 1'b1; beq = 1'b1; Zero = 1'b1;
      Result = (k == 2) ? 32'h301 : 32'h200; ReadData = 32'hFFFF_FFFF;
      #1;
      checkOutput($sformatf("halt%0d.PCWrite", k), PCWrite, 1'b0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("halt%0d.PC", k),      PC, 32'h6C);
      checkOutput($sformatf("halt%0d.Instr", k),   Instr, 32'h12345678);
      checkOutput($sformatf("halt%0d.OldPC", k),   OldPC, 32'h6C);
      checkOutput($sformatf("halt%0d.instret", k), instret_cnt, 32'd4);
      checkOutput($sformatf("halt%0d.cycle", k),   cycle_cnt, 32'd17);
      checkOutput($sformatf("halt%0d.halted", k),  halted, 1'b1);
      checkOutput($sformatf("halt%0d.trap_pc", k), trap_pc, 32'h102);
    end

    // Asynchronous reset while halted, between clock edges
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("areset_halt");

    // Release and fetch again from the reset PC
    @(negedge clk);
    reset = 1'b1;
    clearInputs();
    PCUpdate = 1'b1; IRWrite = 1'b1; Result = 32'h8; ReadData = 32'h00100113;
    @(posedge clk);
    #1;
    checkOutput("resume.PC",      PC, 32'h8);
    checkOutput("resume.OldPC",   OldPC, 32'h0);
    checkOutput("resume.Instr",   Instr, 32'h00100113);
    checkOutput("resume.halted",  halted, 1'b0);
    checkOutput("resume.instret", instret_cnt, 32'd1);
    checkOutput("resume.cycle",   cycle_cnt, 32'd1);

    // Asynchronous reset in the middle of a fetch cycle
    @(negedge clk);
    PCUpdate = 1'b1; IRWrite = 1'b1; Result = 32'hC; ReadData = 32'h00200193;
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("areset_fetch");

    // Counter wrap: 16 fetches wrap the 4-bit instret of the narrow copy
    @(negedge clk);
    reset = 1'b1;
    clearInputs();
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      IRWrite  = 1'b1;
      ReadData = 32'h0000_0013;
      @(posedge clk);
      #1;
      if (i == 14) checkOutput("wrap.instret_ones", instret_cnt4, 4'hF);
      if (i == 15) begin
        checkOutput("wrap.instret_zero", instret_cnt4, 4'h0);
        checkOutput("wrap.cycle_zero",   cycle_cnt4, 4'h0);
        checkOutput("wrap.instret_wide", instret_cnt, 32'd16);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net so the run always ends on its own
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
